div_iter: RTL and testbench

Iterative radix-2 integer divider, the companion to the Booth multiplier in the functional-unit library. It accepts one 32-bit dividend/divisor pair per request, with independent signedness per operand, and computes one quotient bit per cycle using restoring division on magnitudes. After a sign-fixup cycle it holds quotient and remainder until the next request. It sits beside the multiplier behind the same request-style operand interface.

---
 rtl/div_iter_pkg.sv | 23 ++
 rtl/div_iter_step.sv | 23 ++
 rtl/div_iter.sv | 109 ++++++++++
 tb/tb_div_iter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative radix-2 divider: width, state encoding,
// iteration count and the special-case result values.
package div_iter_pkg;

   localparam int W         = 32;
   localparam int DIV_STEPS = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [4:0]   LAST_STEP = 5'(DIV_STEPS - 1);
   localparam logic [W-1:0] Q_DIV0    = {W{1'b1}};
   localparam logic [W-1:0] MIN_INT   = {1'b1, {(W-1){1'b0}}};

   // Unsigned magnitude; the most negative value maps onto itself, which is
   // exactly its unsigned magnitude.
   function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_iter_step
   import div_iter_pkg::*;
(
   input  logic [W:0]   i_p,
   input  logic         i_q_msb,
   input  logic [W-1:0] i_d,
   output logic [W:0]   o_p,
   output logic         o_q_bit
);

   logic [W+1:0] w_shift;
   logic [W+1:0] w_trial;

   assign w_shift = {i_p, i_q_msb};
   assign w_trial = w_shift - {2'b00, i_d};

   // A clear sign bit means the divisor fits into the shifted remainder.
   assign o_q_bit = ~w_trial[W+1];
   assign o_p     = o_q_bit ? w_trial[W:0] : w_shift[W:0];

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit divider: 32 restoring steps on operand magnitudes, then a
// fixup cycle for signs, divide-by-zero and signed overflow.
module div_iter
   import div_iter_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   output logic         ready,
   input  logic         x_signed,
   input  logic         y_signed,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         valid,
   output logic [W-1:0] q,
   output logic [W-1:0] r
);

   logic [1:0]   r_state;
   logic [4:0]   r_count;
   logic [W:0]   r_p;
   logic [W-1:0] r_q;
   logic [W-1:0] r_d;
   logic [W-1:0] r_x_orig;
   logic         r_xneg;
   logic         r_yneg;
   logic         r_ovf;
   logic         r_valid;
   logic [W-1:0] r_q_out;
   logic [W-1:0] r_r_out;

   logic         w_accept;
   logic [W:0]   w_next_p;
   logic         w_q_bit;
   logic         w_xneg;
   logic         w_yneg;

   assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign valid    = r_valid;
   assign q        = r_q_out;
   assign r        = r_r_out;
   assign w_accept = ready & req;
   assign w_xneg   = x_signed & x[W-1];
   assign w_yneg   = y_signed & y[W-1];

   div_iter_step u_step (
      .i_p     (r_p),
      .i_q_msb (r_q[W-1]),
      .i_d     (r_d),
      .o_p     (w_next_p),
      .o_q_bit (w_q_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_p      <= '0;
         r_q      <= '0;
         r_d      <= '0;
         r_x_orig <= '0;
         r_xneg   <= 1'b0;
         r_yneg   <= 1'b0;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
         r_q_out  <= '0;
         r_r_out  <= '0;
      end else begin
         case (r_state)
            S_DIV: begin
               r_p     <= w_next_p;
               r_q     <= {r_q[W-2:0], w_q_bit};
               r_count <= r_count + 5'd1;
               if (r_count == LAST_STEP) r_state <= S_FIX;
            end
            S_FIX: begin
               // Divide-by-zero wins over overflow; both bypass the sign fixup.
               if (r_d == '0) begin
                  r_q_out <= Q_DIV0;
                  r_r_out <= r_x_orig;
               end else if (r_ovf) begin
                  r_q_out <= MIN_INT;
                  r_r_out <= '0;
               end else begin
                  r_q_out <= (r_xneg ^ r_yneg) ? (~r_q + 1'b1) : r_q;
                  r_r_out <= r_xneg ? (~r_p[W-1:0] + 1'b1) : r_p[W-1:0];
               end
               r_valid <= 1'b1;
               r_state <= S_DONE;
            end
            default: begin
               if (w_accept) begin
                  r_xneg   <= w_xneg;
                  r_yneg   <= w_yneg;
                  r_q      <= mag(x, w_xneg);
                  r_d      <= mag(y, w_yneg);
                  r_x_orig <= x;
                  r_ovf    <= x_signed & y_signed & (x == MIN_INT) & (y == Q_DIV0);
                  r_p      <= '0;
                  r_count  <= '0;
                  r_valid  <= 1'b0;
                  r_state  <= S_DIV;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: fixed-latency signed/unsigned division, special
// cases, busy-request immunity, asynchronous reset and back-to-back requests.
module tb_div_iter;

   logic        clk;
   logic        reset;
   logic        req;
   logic        ready;
   logic        x_signed;
   logic        y_signed;
   logic [31:0] x;
   logic [31:0] y;
   logic        valid;
   logic [31:0] q;
   logic [31:0] r;

   int          checks;
   int          failures;
   logic [31:0] last_q;
   logic [31:0] last_r;

   div_iter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .ready    (ready),
      .x_signed (x_signed),
      .y_signed (y_signed),
      .x        (x),
      .y        (y),
      .valid    (valid),
      .q        (q),
      .r        (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT ready. Accepts one request, optionally
   // pulses req again mid-operation, then checks latency, busy flags, stability
   // of the previous result and the final q/r.
   task automatic run_div(input string tag, input logic xs, input logic ys,
                          input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int pulse_at);
      int   n;
      logic busy_bad;
      logic hold_bad;
      req      = 1'b1;
      x_signed = xs;
      y_signed = ys;
      x        = xv;
      y        = yv;
      @(posedge clk);
      @(negedge clk);
      n        = 0;
      busy_bad = 1'b0;
      hold_bad = 1'b0;
      while (valid !== 1'b1 && n < 100) begin
         if (ready !== 1'b0) busy_bad = 1'b1;
         if (q !== last_q || r !== last_r) hold_bad = 1'b1;
         req      = (n == pulse_at);
         x        = $urandom;
         y        = $urandom;
         x_signed = 1'($urandom_range(0, 1));
         y_signed = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      req = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'd33);
      check({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
      check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
      check({tag, "_ready"}, {31'd0, ready}, 32'd1);
      check({tag, "_q"}, q, eq);
      check({tag, "_r"}, r, er);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      last_q   = '0;
      last_r   = '0;
      reset    = 1'b1;
      req      = 1'b0;
      x_signed = 1'b0;
      y_signed = 1'b0;
      x        = '0;
      y        = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_q", q, 32'd0);
      check("rst_r", r, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_div("u100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, -1);
      // Request held in the first DONE cycle.
      run_div("b2b_1000_10", 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, -1);
      @(negedge clk);
      check("done_hold_valid", {31'd0, valid}, 32'd1);
      check("done_hold_q", q, 32'd100);

      run_div("s_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
      run_div("s_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1);
      run_div("mixed", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, -1);
      run_div("div0_u", 1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, -1);
      run_div("div0_s", 1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, -1);
      run_div("ovf_s", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
      run_div("ovf_u", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1);
      run_div("minint_s_1", 1'b1, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, -1);
      run_div("u_big", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, -1);
      run_div("busy_req", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5);

      // Asynchronous reset partway through the iterations.
      @(negedge clk);
      req      = 1'b1;
      x_signed = 1'b0;
      y_signed = 1'b0;
      x        = 32'd1000;
      y        = 32'd3;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", {31'd0, ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ready", {31'd0, ready}, 32'd1);
      check("async_rst_valid", {31'd0, valid}, 32'd0);
      check("async_rst_q", q, 32'd0);
      check("async_rst_r", r, 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      last_q = '0;
      last_r = '0;
      @(negedge clk);
      check("post_rst_valid", {31'd0, valid}, 32'd0);
      run_div("after_rst", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
